rs_queue: RTL and testbench

- Multi-entry reservation station, successor to the single-entry RS; sits between the issue/rename stage and one functional unit.
- Holds up to DEPTH in-flight operations and captures operands by tag from NUM_BCAST common-data-bus channels.
- Dispatches the oldest fully-resolved entry to the unit over a valid/ready handshake.
- Frees an entry on dispatch rather than on retire, so the unit can be pipelined.

---
 rtl/rs_queue.sv | 179 +++++++++++++++++
 tb/tb_rs_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_queue.sv
// rtl/rs_queue.sv - multi-entry reservation station with tag wakeup and oldest-ready select
module rs_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int OP_WIDTH   = 16,
  parameter int NUM_BCAST  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [OP_WIDTH-1:0]             issue_op_i,
  input  logic [TAG_WIDTH-1:0]            issue_dest_tag_i,
  input  logic                            src1_virtual_i,
  input  logic                            src2_virtual_i,
  input  logic [TAG_WIDTH-1:0]            src1_tag_i,
  input  logic [TAG_WIDTH-1:0]            src2_tag_i,
  input  logic [DATA_WIDTH-1:0]           src1_value_i,
  input  logic [DATA_WIDTH-1:0]           src2_value_i,
  input  logic [NUM_BCAST-1:0]            bcast_en_i,
  input  logic [NUM_BCAST*TAG_WIDTH-1:0]  bcast_tag_i,
  input  logic [NUM_BCAST*DATA_WIDTH-1:0] bcast_data_i,
  output logic                            dispatch_valid_o,
  input  logic                            dispatch_ready_i,
  output logic [OP_WIDTH-1:0]             dispatch_op_o,
  output logic [TAG_WIDTH-1:0]            dispatch_dest_tag_o,
  output logic [DATA_WIDTH-1:0]           dispatch_op1_o,
  output logic [DATA_WIDTH-1:0]           dispatch_op2_o,
  input  logic                            flush_i,
  output logic [$clog2(DEPTH+1)-1:0]      count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]      valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
  logic [OP_WIDTH-1:0]   op_q [DEPTH];
  logic [OP_WIDTH-1:0]   op_d [DEPTH];
  logic [TAG_WIDTH-1:0]  dtag_q [DEPTH];
  logic [TAG_WIDTH-1:0]  dtag_d [DEPTH];
  logic [TAG_WIDTH-1:0]  t1_q [DEPTH];
  logic [TAG_WIDTH-1:0]  t1_d [DEPTH];
  logic [TAG_WIDTH-1:0]  t2_q [DEPTH];
  logic [TAG_WIDTH-1:0]  t2_d [DEPTH];
  logic [DATA_WIDTH-1:0] v1_q [DEPTH];
  logic [DATA_WIDTH-1:0] v1_d [DEPTH];
  logic [DATA_WIDTH-1:0] v2_q [DEPTH];
  logic [DATA_WIDTH-1:0] v2_d [DEPTH];
  // older_q[i][j] set means entry i was issued before entry j
  logic [DEPTH-1:0]      older_q [DEPTH];
  logic [DEPTH-1:0]      older_d [DEPTH];
  logic [CW-1:0]         count_q, count_d;

  logic [DEPTH-1:0]      ready;
  logic [IW-1:0]         free_idx, sel_idx;
  logic                  issue_fire, disp_fire;
  logic [DATA_WIDTH:0]   hit1 [DEPTH];
  logic [DATA_WIDTH:0]   hit2 [DEPTH];
  logic [DATA_WIDTH:0]   ihit1, ihit2;

  // Returns {hit, data}; lowest matching channel wins.
  function automatic logic [DATA_WIDTH:0] snoop(
    input logic [TAG_WIDTH-1:0]            tag,
    input logic [NUM_BCAST-1:0]            en,
    input logic [NUM_BCAST*TAG_WIDTH-1:0]  tags,
    input logic [NUM_BCAST*DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH:0] r;
    r = '0;
    for (int k = NUM_BCAST-1; k >= 0; k--) begin
      if (en[k] && tags[k*TAG_WIDTH +: TAG_WIDTH] == tag)
        r = {1'b1, data[k*DATA_WIDTH +: DATA_WIDTH]};
    end
    return r;
  endfunction

  always_comb begin
    ihit1 = snoop(src1_tag_i, bcast_en_i, bcast_tag_i, bcast_data_i);
    ihit2 = snoop(src2_tag_i, bcast_en_i, bcast_tag_i, bcast_data_i);
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = snoop(t1_q[i], bcast_en_i, bcast_tag_i, bcast_data_i);
      hit2[i] = snoop(t2_q[i], bcast_en_i, bcast_tag_i, bcast_data_i);
    end
  end

  always_comb begin
    ready    = valid_q & r1_q & r2_q;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic beaten;
      beaten = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older_q[j][i]) beaten = 1'b1;
      end
      if (ready[i] && !beaten) sel_idx = IW'(i);
    end
  end

  assign issue_ready_o       = (count_q != CW'(DEPTH));
  assign dispatch_valid_o    = (|ready) && !flush_i;
  assign dispatch_op_o       = op_q[sel_idx];
  assign dispatch_dest_tag_o = dtag_q[sel_idx];
  assign dispatch_op1_o      = v1_q[sel_idx];
  assign dispatch_op2_o      = v2_q[sel_idx];
  assign count_o             = count_q;

  assign issue_fire = issue_valid_i && issue_ready_o && !flush_i;
  assign disp_fire  = dispatch_valid_o && dispatch_ready_i;

  always_comb begin
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    op_d    = op_q;
    dtag_d  = dtag_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !r1_q[i] && hit1[i][DATA_WIDTH]) begin
        r1_d[i] = 1'b1;
        v1_d[i] = hit1[i][DATA_WIDTH-1:0];
      end
      if (valid_q[i] && !r2_q[i] && hit2[i][DATA_WIDTH]) begin
        r2_d[i] = 1'b1;
        v2_d[i] = hit2[i][DATA_WIDTH-1:0];
      end
    end
    if (disp_fire) valid_d[sel_idx] = 1'b0;
    if (issue_fire) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = issue_op_i;
      dtag_d[free_idx]  = issue_dest_tag_i;
      t1_d[free_idx]    = src1_tag_i;
      t2_d[free_idx]    = src2_tag_i;
      r1_d[free_idx]    = !src1_virtual_i || ihit1[DATA_WIDTH];
      r2_d[free_idx]    = !src2_virtual_i || ihit2[DATA_WIDTH];
      v1_d[free_idx]    = src1_virtual_i ? ihit1[DATA_WIDTH-1:0] : src1_value_i;
      v2_d[free_idx]    = src2_virtual_i ? ihit2[DATA_WIDTH-1:0] : src2_value_i;
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) older_d[j][free_idx] = 1'b1;
      end
    end
    if (flush_i) valid_d = '0;
    count_d = flush_i ? '0 : count_q + CW'(issue_fire) - CW'(disp_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      count_q <= count_d;
      older_q <= older_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    dtag_q <= dtag_d;
    t1_q   <= t1_d;
    t2_q   <= t2_d;
    v1_q   <= v1_d;
    v2_q   <= v2_d;
  end
endmodule

// File: tb/tb_rs_queue.sv
// tb/tb_rs_queue.sv - scoreboard bench for rs_queue
module tb_rs_queue;
  logic        clk = 0;
  logic        rst;
  logic        issue_valid_i, issue_ready_o;
  logic [15:0] issue_op_i;
  logic [3:0]  issue_dest_tag_i;
  logic        src1_virtual_i, src2_virtual_i;
  logic [3:0]  src1_tag_i, src2_tag_i;
  logic [31:0] src1_value_i, src2_value_i;
  logic [1:0]  bcast_en_i;
  logic [7:0]  bcast_tag_i;
  logic [63:0] bcast_data_i;
  logic        dispatch_valid_o, dispatch_ready_i;
  logic [15:0] dispatch_op_o;
  logic [3:0]  dispatch_dest_tag_o;
  logic [31:0] dispatch_op1_o, dispatch_op2_o;
  logic        flush_i;
  logic [2:0]  count_o;

  rs_queue dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_dest_tag_i(issue_dest_tag_i),
    .src1_virtual_i(src1_virtual_i), .src2_virtual_i(src2_virtual_i),
    .src1_tag_i(src1_tag_i), .src2_tag_i(src2_tag_i),
    .src1_value_i(src1_value_i), .src2_value_i(src2_value_i),
    .bcast_en_i(bcast_en_i), .bcast_tag_i(bcast_tag_i), .bcast_data_i(bcast_data_i),
    .dispatch_valid_o(dispatch_valid_o), .dispatch_ready_i(dispatch_ready_i),
    .dispatch_op_o(dispatch_op_o), .dispatch_dest_tag_o(dispatch_dest_tag_o),
    .dispatch_op1_o(dispatch_op1_o), .dispatch_op2_o(dispatch_op2_o),
    .flush_i(flush_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] op;
    logic [3:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dispatch_valid_o && dispatch_ready_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_dispatch", {48'd0, dispatch_op_o}, 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("disp_op",  64'(dispatch_op_o), 64'(e.op));
        chk("disp_tag", 64'(dispatch_dest_tag_o), 64'(e.tag));
        chk("disp_op1", 64'(dispatch_op1_o), 64'(e.a));
        chk("disp_op2", 64'(dispatch_op2_o), 64'(e.b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_issue(input logic [15:0] op, input logic [3:0] dt,
                           input logic v1, input logic [3:0] t1, input logic [31:0] x1,
                           input logic v2, input logic [3:0] t2, input logic [31:0] x2);
    issue_valid_i    = 1'b1;
    issue_op_i       = op;
    issue_dest_tag_i = dt;
    src1_virtual_i   = v1; src1_tag_i = t1; src1_value_i = x1;
    src2_virtual_i   = v2; src2_tag_i = t2; src2_value_i = x2;
  endtask

  task automatic set_bcast(input logic [1:0] en, input logic [3:0] tg0, input logic [31:0] d0,
                           input logic [3:0] tg1, input logic [31:0] d1);
    bcast_en_i   = en;
    bcast_tag_i  = {tg1, tg0};
    bcast_data_i = {d1, d0};
  endtask

  initial begin
    rst = 1; issue_valid_i = 0; issue_op_i = 0; issue_dest_tag_i = 0;
    src1_virtual_i = 0; src2_virtual_i = 0; src1_tag_i = 0; src2_tag_i = 0;
    src1_value_i = 0; src2_value_i = 0; bcast_en_i = 0; bcast_tag_i = 0; bcast_data_i = 0;
    dispatch_ready_i = 0; flush_i = 0;
    repeat (3) step();
    rst = 0;
    mid();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_disp_valid", 64'(dispatch_valid_o), 64'd0);

    // basic non-virtual issue and dispatch
    step();
    dispatch_ready_i = 1;
    set_issue(16'h0011, 4'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7);
    sb_q.push_back('{16'h0011, 4'd3, 32'd5, 32'd7});
    step(); issue_valid_i = 0;
    mid();
    chk("t1_valid", 64'(dispatch_valid_o), 64'd1);
    chk("t1_count1", 64'(count_o), 64'd1);
    step(); mid();
    chk("t1_count0", 64'(count_o), 64'd0);

    // wakeup on channel 1, two cycles after issue
    set_issue(16'h0022, 4'd4, 1, 4'd2, 32'd0, 0, 4'd0, 32'd1);
    sb_q.push_back('{16'h0022, 4'd4, 32'hDEAD, 32'd1});
    step(); issue_valid_i = 0;
    mid(); chk("t2_wait0", 64'(dispatch_valid_o), 64'd0);
    step();
    set_bcast(2'b10, 4'd0, 32'd0, 4'd2, 32'hDEAD);
    mid(); chk("t2_no_comb_bypass", 64'(dispatch_valid_o), 64'd0);
    step(); set_bcast(2'b00, 0, 0, 0, 0);
    mid(); chk("t2_woken", 64'(dispatch_valid_o), 64'd1);
    step();

    // same-cycle issue bypass on channel 0
    set_issue(16'h0033, 4'd6, 0, 4'd0, 32'd9, 1, 4'd5, 32'd0);
    set_bcast(2'b01, 4'd5, 32'h42, 4'd0, 32'd0);
    sb_q.push_back('{16'h0033, 4'd6, 32'd9, 32'h42});
    step(); issue_valid_i = 0; set_bcast(2'b00, 0, 0, 0, 0);
    mid(); chk("t3_bypass_valid", 64'(dispatch_valid_o), 64'd1);
    step();

    // fill to DEPTH, fifth issue ignored
    dispatch_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      set_issue(16'h0040 + 16'(i), 4'(8 + i), 0, 4'd0, 32'(i), 0, 4'd0, 32'(100 + i));
      sb_q.push_back('{16'h0040 + 16'(i), 4'(8 + i), 32'(i), 32'(100 + i)});
      step();
    end
    set_issue(16'h004F, 4'd15, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
    mid();
    chk("t4_full_ready", 64'(issue_ready_o), 64'd0);
    chk("t4_full_count", 64'(count_o), 64'd4);
    step(); issue_valid_i = 0;
    mid(); chk("t4_still_full", 64'(count_o), 64'd4);
    chk("t4_hold_op", 64'(dispatch_op_o), 64'h0040);
    step();
    dispatch_ready_i = 1;
    step(); dispatch_ready_i = 0;
    mid();
    chk("t4_ready_again", 64'(issue_ready_o), 64'd1);
    chk("t4_count3", 64'(count_o), 64'd3);
    step();
    dispatch_ready_i = 1;
    repeat (3) step();
    mid(); chk("t4_drained", 64'(count_o), 64'd0);
    step();

    // age: older waiting entry wins once woken
    dispatch_ready_i = 0;
    set_issue(16'h0051, 4'd12, 1, 4'd1, 32'd0, 0, 4'd0, 32'd2);
    sb_q.push_back('{16'h0051, 4'd12, 32'h77, 32'd2});
    step();
    set_issue(16'h0052, 4'd13, 0, 4'd0, 32'd3, 0, 4'd0, 32'd4);
    sb_q.push_back('{16'h0052, 4'd13, 32'd3, 32'd4});
    step(); issue_valid_i = 0;
    mid(); chk("t5_b_first", 64'(dispatch_op_o), 64'h0052);
    set_bcast(2'b01, 4'd1, 32'h77, 4'd0, 32'd0);
    step(); set_bcast(2'b00, 0, 0, 0, 0);
    mid(); chk("t5_older_a", 64'(dispatch_op_o), 64'h0051);
    step();
    mid(); chk("t5_stable_a", 64'(dispatch_op_o), 64'h0051);
    step();
    dispatch_ready_i = 1;
    step(); step();
    dispatch_ready_i = 0;
    mid(); chk("t5_count0", 64'(count_o), 64'd0);
    step();

    // lowest broadcast channel wins on multi-match
    dispatch_ready_i = 1;
    set_issue(16'h0070, 4'd1, 1, 4'd7, 32'd0, 0, 4'd0, 32'd5);
    sb_q.push_back('{16'h0070, 4'd1, 32'hA0, 32'd5});
    step(); issue_valid_i = 0;
    set_bcast(2'b11, 4'd7, 32'hA0, 4'd7, 32'hB0);
    step(); set_bcast(2'b00, 0, 0, 0, 0);
    step(); step();

    // flush overrides issue and dispatch
    dispatch_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      set_issue(16'h0060 + 16'(i), 4'(i), 0, 4'd0, 32'd1, 0, 4'd0, 32'd2);
      step();
    end
    mid(); chk("t6_count3", 64'(count_o), 64'd3);
    step();
    set_issue(16'h006F, 4'd9, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
    flush_i = 1; dispatch_ready_i = 1;
    mid(); chk("t6_flush_no_disp", 64'(dispatch_valid_o), 64'd0);
    step(); flush_i = 0; issue_valid_i = 0;
    mid();
    chk("t6_flush_count", 64'(count_o), 64'd0);
    chk("t6_flush_valid", 64'(dispatch_valid_o), 64'd0);
    step(); step();

    // reset mid-operation
    dispatch_ready_i = 0;
    set_issue(16'h0080, 4'd2, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
    step(); issue_valid_i = 0;
    mid(); chk("t7_pre_rst", 64'(count_o), 64'd1);
    step(); rst = 1;
    step(); rst = 0;
    dispatch_ready_i = 1;
    mid();
    chk("t7_rst_count", 64'(count_o), 64'd0);
    chk("t7_rst_valid", 64'(dispatch_valid_o), 64'd0);
    step(); step();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
